// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-rate serializer.
// tx and the line-activity flag are registered one clock behind the serializer state.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ_HZ = 615000,
  parameter int unsigned BAUD_RATE   = 56000,
  parameter int unsigned DEPTH       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  input  logic                     clr_overflow,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     overflow,
  output logic                     tx
);

  localparam int unsigned DIV = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;

  state_e        state_q, state_d;
  logic [7:0]    sh_q, sh_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          tx_q, tx_d;
  logic          line_q, line_d;

  logic          push_ok;
  logic          drop;
  logic          pop;
  logic          bit_end;

  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign overflow = ovf_q;
  assign tx       = tx_q;
  // line_q covers the final stop-bit clock still on the wire after the FSM returns to IDLE
  assign busy     = line_q | (state_q != S_IDLE) | ~empty;

  assign push_ok = wr_valid & ~full;
  assign drop    = wr_valid & full;
  assign bit_end = (cnt_q == CW'(DIV - 1));

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    level_d = level_q + LW'(push_ok) - LW'(pop);
    ovf_d = ovf_q;
    if (drop)              ovf_d = 1'b1;
    else if (clr_overflow) ovf_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = mem[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = mem[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = sh_q[0];
      default: tx_d = 1'b1;
    endcase
    line_d = (state_q != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      line_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      line_q   <= line_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at default parameters (DIV=11, 110-clock frames).
// A background receiver decodes tx mid-bit and queues frames with their start cycle.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_valid = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       full, empty, busy, overflow, tx;
  logic [4:0] level;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] b;
    int         start;
    logic       start_ok;
    logic       stop_ok;
  } frame_t;

  frame_t fq[$];
  frame_t mf;

  uart_tx_fifo #(
    .CLK_FREQ_HZ(615000),
    .BAUD_RATE  (56000),
    .DEPTH      (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_data     (wr_data),
    .wr_valid    (wr_valid),
    .clr_overflow(clr_overflow),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .busy        (busy),
    .overflow    (overflow),
    .tx          (tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && reset === 1'b0) begin
        mf.start = cyc;
        repeat (5) @(negedge clk);
        mf.start_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (11) @(negedge clk);
          mf.b[i] = tx;
        end
        repeat (11) @(negedge clk);
        mf.stop_ok = (tx === 1'b1);
        fq.push_back(mf);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_data  = b;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [7:0] exp, output int start);
    frame_t f;
    start = 0;
    chk({tag, " present"}, 32'(fq.size() > 0), 32'd1);
    if (fq.size() > 0) begin
      f = fq.pop_front();
      chk({tag, " data"}, 32'(f.b), 32'(exp));
      chk({tag, " framing"}, 32'(f.start_ok & f.stop_ok), 32'd1);
      start = f.start;
    end
  endtask

  initial begin
    int s0, s1, s2;
    logic [7:0] v;
    logic ok, busy_last;

    // 1: reset state
    tick(); tick();
    chk("rst tx", 32'(tx), 32'd1);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst level", 32'(level), 32'd0);
    reset = 1'b0;
    tick();
    chk("post-rst busy", 32'(busy), 32'd0);
    chk("post-rst overflow", 32'(overflow), 32'd0);
    chk("post-rst full", 32'(full), 32'd0);
    chk("post-rst tx", 32'(tx), 32'd1);

    // 1b: reset mid-frame
    push(8'hA5);
    push(8'h5A);
    chk("midrst level pre", 32'(level), 32'd1);
    tick(); tick(); tick(); tick();
    chk("midrst tx low pre", 32'(tx), 32'd0);
    reset = 1'b1;
    #1;
    chk("midrst tx async", 32'(tx), 32'd1);
    chk("midrst level", 32'(level), 32'd0);
    chk("midrst empty", 32'(empty), 32'd1);
    chk("midrst busy", 32'(busy), 32'd0);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("midrst level post", 32'(level), 32'd0);
    chk("midrst tx post", 32'(tx), 32'd1);
    chk("midrst busy post", 32'(busy), 32'd0);
    repeat (120) tick();
    fq.delete();

    // 2: single 0x55 frame with exact timing
    push(8'h55);
    chk("t2 level N", 32'(level), 32'd1);
    chk("t2 busy N", 32'(busy), 32'd1);
    chk("t2 tx N", 32'(tx), 32'd1);
    tick();
    chk("t2 tx N+1", 32'(tx), 32'd1);
    chk("t2 level N+1", 32'(level), 32'd0);
    chk("t2 busy N+1", 32'(busy), 32'd1);
    tick();
    v = 8'h55;
    busy_last = 1'b0;
    for (int k = 0; k < 10; k++) begin
      ok = 1'b1;
      for (int c = 0; c < 11; c++) begin
        if (k == 0) begin
          if (tx !== 1'b0) ok = 1'b0;
        end else if (k == 9) begin
          if (tx !== 1'b1) ok = 1'b0;
        end else begin
          if (tx !== v[k-1]) ok = 1'b0;
        end
        if (k == 9 && c == 10) busy_last = busy;
        tick();
      end
      chk($sformatf("t2 bit slot %0d", k), 32'(ok), 32'd1);
    end
    chk("t2 busy N+111", 32'(busy_last), 32'd1);
    chk("t2 busy N+112", 32'(busy), 32'd0);
    chk("t2 tx N+112", 32'(tx), 32'd1);
    repeat (10) tick();
    chk_frame("t2 rx", 8'h55, s0);

    // 3: three back-to-back frames "ABC"
    push(8'h41);
    chk("t3 level A", 32'(level), 32'd1);
    push(8'h42);
    chk("t3 level B", 32'(level), 32'd1);
    push(8'h43);
    chk("t3 level C", 32'(level), 32'd2);
    repeat (350) tick();
    chk_frame("t3 A", 8'h41, s0);
    chk_frame("t3 B", 8'h42, s1);
    chk_frame("t3 C", 8'h43, s2);
    chk("t3 gap AB", 32'(s1 - s0), 32'd110);
    chk("t3 gap BC", 32'(s2 - s1), 32'd110);
    chk("t3 idle busy", 32'(busy), 32'd0);

    // 4: fill to full, then overflow
    for (int i = 0; i < 17; i++) begin
      push(8'h60 + 8'(i));
      chk($sformatf("t4 level push %0d", i), 32'(level), (i == 0) ? 32'd1 : 32'(i));
    end
    chk("t4 full", 32'(full), 32'd1);
    chk("t4 overflow clean", 32'(overflow), 32'd0);
    push(8'hEE);
    chk("t4 drop full", 32'(full), 32'd1);
    chk("t4 drop overflow", 32'(overflow), 32'd1);
    chk("t4 drop level", 32'(level), 32'd16);

    // 5: overflow clear and set-wins
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t5 clr alone", 32'(overflow), 32'd0);
    clr_overflow = 1'b1;
    push(8'hEF);
    clr_overflow = 1'b0;
    chk("t5 set wins", 32'(overflow), 32'd1);
    chk("t5 level", 32'(level), 32'd16);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    chk("t5 clr again", 32'(overflow), 32'd0);
    repeat (1910) tick();
    chk("t4 rx count", 32'(fq.size()), 32'd17);
    for (int i = 0; i < 17; i++) chk_frame($sformatf("t4 rx %0d", i), 8'h60 + 8'(i), s0);
    chk("t4 drained", 32'(empty), 32'd1);

    // 6: push exactly as STOP ends with the FIFO empty
    push(8'h3C);
    repeat (110) tick();
    push(8'hC3);
    chk("t6 level N+111", 32'(level), 32'd1);
    chk("t6 tx N+111", 32'(tx), 32'd1);
    tick();
    chk("t6 level N+112", 32'(level), 32'd0);
    chk("t6 tx N+112", 32'(tx), 32'd1);
    chk("t6 busy N+112", 32'(busy), 32'd1);
    tick();
    chk("t6 tx N+113", 32'(tx), 32'd0);
    repeat (130) tick();
    chk_frame("t6 first", 8'h3C, s0);
    chk_frame("t6 second", 8'hC3, s1);
    chk("t6 gap", 32'(s1 - s0), 32'd111);

    // pointer wrap: bytes 24..40 since reset
    for (int i = 0; i < 17; i++) begin
      push(8'h80 + 8'(i));
      chk($sformatf("wrap level push %0d", i), 32'(level), (i == 0) ? 32'd1 : 32'(i));
    end
    chk("wrap full", 32'(full), 32'd1);
    repeat (1910) tick();
    chk("wrap rx count", 32'(fq.size()), 32'd17);
    for (int i = 0; i < 17; i++) chk_frame($sformatf("wrap rx %0d", i), 8'h80 + 8'(i), s0);
    chk("wrap level end", 32'(level), 32'd0);
    chk("wrap empty end", 32'(empty), 32'd1);
    chk("wrap busy end", 32'(busy), 32'd0);
    chk("wrap overflow end", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
